// File: rtl/ramb4_s4_ctrl.sv
// Initiator-side controller for a 1024x4 single-port block RAM: valid/ready request
// port, 3-entry in-order read response FIFO, and a full-array clear engine.
module ramb4_s4_ctrl #(
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    DATA_WIDTH     = 4,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  input  logic                  CLR_START,
  output logic                  BUSY,
  output logic                  CLR_DONE,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] fifo_q [0:2];
  logic [1:0]            rd_ptr_q;
  logic [1:0]            wr_ptr_q;
  logic [1:0]            count_q;
  logic                  inflight_q;
  logic                  clr_done_q;

  logic                  req_ready_s;
  logic                  accept_s;
  logic                  rsp_valid_s;
  logic                  pop_s;
  logic                  ram_en_s;
  logic                  ram_we_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_di_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Per-cycle decision: RAM pins and handshake, forced idle while RST is high
  always_comb begin
    req_ready_s = 1'b0;
    accept_s    = 1'b0;
    ram_en_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = REQ_ADDR;
    ram_di_s    = REQ_DATA;
    if (RST) begin
      req_ready_s = 1'b0;
    end else if (state_q == S_CLEAR) begin
      ram_en_s   = 1'b1;
      ram_we_s   = 1'b1;
      ram_addr_s = cnt_q[ADDR_WIDTH-1:0];
      ram_di_s   = CLEAR_VALUE;
    end else begin
      // Inflight read already owns a slot, so it counts toward the limit
      req_ready_s = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
      accept_s    = REQ_VALID & req_ready_s;
      ram_en_s    = accept_s;
      ram_we_s    = accept_s & REQ_WE;
    end
  end

  assign rsp_valid_s = ~RST & (count_q != 2'd0);
  assign pop_s       = rsp_valid_s & RSP_READY;

  // State machine, clear counter, read pipeline and response FIFO
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      cnt_q      <= '0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      inflight_q <= accept_s & ~REQ_WE;
      case (state_q)
        S_IDLE: begin
          if (CLR_START) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= RAM_DO;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({inflight_q, pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign REQ_READY = req_ready_s;
  assign RSP_VALID = rsp_valid_s;
  assign RSP_DATA  = fifo_q[rd_ptr_q];
  assign BUSY      = (state_q == S_CLEAR);
  assign CLR_DONE  = clr_done_q;
  assign RAM_EN    = ram_en_s;
  assign RAM_WE    = ram_we_s;
  assign RAM_ADDR  = ram_addr_s;
  assign RAM_DI    = ram_di_s;

endmodule

// File: doc/ramb4_s4_ctrl.md
Name: ramb4_s4_ctrl

Overview:
Initiator-side controller for the 1024x4 single-port block RAM primitive (sync write, 1-cycle registered read, write-first DO). Accepts read/write requests from a client over a valid/ready handshake and drives the RAM EN/WE/ADDR/DI pins. It returns read data through a 3-entry response FIFO with backpressure. It also contains a clear engine that sweeps the whole array with a constant after reset or on command.

Parameters:
ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 4, RAM word width
CLEAR_ON_RESET, 1, 1 = run a full clear sweep when RST deasserts; 0 = go straight to IDLE
CLEAR_VALUE, 4'h0, word written to every address by the clear engine

Ports:
CLK  in  1  clock; all logic on posedge
RST  in  1  synchronous active-high reset
REQ_VALID  in  1  client request valid
REQ_READY  out  1  controller can accept a request this cycle
REQ_WE  in  1  1 = write, 0 = read
REQ_ADDR  in  ADDR_WIDTH  request address
REQ_DATA  in  DATA_WIDTH  write data
RSP_VALID  out  1  read response available at FIFO head
RSP_READY  in  1  client consumes the response
RSP_DATA  out  DATA_WIDTH  read data at FIFO head
CLR_START  in  1  single-cycle request to start a clear sweep
BUSY  out  1  clear sweep in progress
CLR_DONE  out  1  one-cycle pulse after the last clear write
RAM_EN  out  1  to RAM EN
RAM_WE  out  1  to RAM WE
RAM_ADDR  out  ADDR_WIDTH  to RAM ADDR
RAM_DI  out  DATA_WIDTH  to RAM DI
RAM_DO  in  DATA_WIDTH  from RAM DO

Behaviour:
- States: IDLE, CLEAR. BUSY = (state==CLEAR).
- Reset while RST=1:
  - state <= CLEAR_ON_RESET ? CLEAR : IDLE; clear counter <= 0.
  - FIFO emptied; in-flight flag <= 0; CLR_DONE <= 0.
  - RAM_EN, RAM_WE, REQ_READY and RSP_VALID are forced 0 combinationally during RST.
  - RST mid-sweep restarts the sweep from address 0.
  - RST discards buffered and in-flight responses.
- RAM pins are combinational from the current cycle's decision; the RAM samples them at the next CLK edge.
- IDLE:
  - REQ_READY = (fifo_count + inflight) < 3.
  - Accept = REQ_VALID & REQ_READY. On accept: RAM_EN=1, RAM_WE=REQ_WE, RAM_ADDR=REQ_ADDR, RAM_DI=REQ_DATA.
  - No accept: RAM_EN=0, RAM_WE=0.
  - A read accept sets inflight <= 1 for the next cycle; otherwise inflight <= 0.
- Read pipeline, read accepted in cycle N:
  - RAM_DO is valid in cycle N+1 and is pushed into the FIFO at the end of N+1.
  - RSP_VALID rises in N+2. Read latency is 2 cycles.
  - RAM_DO is captured only when inflight=1; DO produced by writes or clear writes is never captured.
- FIFO:
  - 3 entries, in order. RSP_DATA = head; pop on RSP_VALID & RSP_READY.
  - Simultaneous push and pop in the same cycle keeps the count unchanged.
  - Overflow is impossible by the REQ_READY rule.
  - Continuous RSP_READY=1 sustains one read per cycle with no bubbles.
- Write then read of the same address in consecutive cycles returns the new data.
- CLEAR:
  - REQ_READY=0.
  - Each cycle: RAM_EN=1, RAM_WE=1, RAM_ADDR=counter, RAM_DI=CLEAR_VALUE; counter += 1.
  - After address 2**ADDR_WIDTH-1 is written, state <= IDLE and CLR_DONE pulses high for exactly the first IDLE cycle.
  - A sweep takes exactly 2**ADDR_WIDTH cycles.
  - The counter is ADDR_WIDTH+1 bits; only its low ADDR_WIDTH bits drive RAM_ADDR.
- CLR_START:
  - Sampled only in IDLE with RST=0; ignored while in CLEAR.
  - If CLR_START and a request are valid in the same IDLE cycle, the request is accepted and CLEAR begins on the next cycle.
  - A read in flight or buffered when the sweep starts completes and is delivered normally; the FIFO still drains during CLEAR.

Test Plan:
- Reset sweep, CLEAR_ON_RESET=1, CLEAR_VALUE=4'h5: release RST -> BUSY=1 for exactly 1024 cycles, RAM_ADDR runs 0..1023 with RAM_WE=1 and RAM_DI=5. CLR_DONE pulses once, then REQ_READY=1. Reads of 0, 511 and 1023 return 5.
- Write/read: write 4'hA@3, then read @3 in the next cycle -> RSP_VALID two cycles after the read accept, RSP_DATA=A. Read @4 returns 5.
- Streaming: 8 back-to-back reads of addresses 0..7 preloaded with 0..7, RSP_READY=1 -> REQ_READY never drops, responses 0..7 arrive in 8 consecutive cycles.
- Backpressure: RSP_READY=0 while issuing reads -> exactly 3 reads accepted, then REQ_READY=0. Raising RSP_READY drains 3 responses in order, and REQ_READY re-asserts the cycle after the first pop.
- Clear on command: CLR_START together with a read of @7 (holding 9) -> read accepted and RSP_DATA=9 delivered during CLEAR. REQ_READY=0 for 1024 cycles. CLR_START pulsed mid-sweep has no effect.
- Mid-sweep reset: RST asserted at sweep address 300 for 2 cycles -> FIFO empty, RSP_VALID=0, and the sweep restarts at address 0 and lasts a full 1024 cycles.
